// File: rtl/mdio_pkg.sv
// Shared types and constants for the MDIO management master: FSM states,
// start-of-frame codes, opcodes and per-field bit counts.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_END
  } state_t;

  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;

  localparam logic [1:0] OP_C22_WRITE = 2'b01;
  localparam logic [1:0] OP_C22_READ  = 2'b10;
  localparam logic [1:0] OP_C45_ADDR  = 2'b00;
  localparam logic [1:0] OP_C45_WRITE = 2'b01;
  localparam logic [1:0] OP_C45_RINC  = 2'b10;
  localparam logic [1:0] OP_C45_READ  = 2'b11;

  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam int HDR_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;

endpackage

// File: rtl/mdc_clk_div.sv
// MDC generator: counts CLK_DIV cycles per half-period while a frame is active
// and strobes the edge that will raise or lower MDC.
module mdc_clk_div #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic srst,
  input  logic start,
  input  logic run,
  output logic mdc,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  // Ticks mark the last cycle of a half-period; the flop update lands on that edge.
  assign wrap      = run && (cnt == CNT_LAST);
  assign rise_tick = wrap && !mdc;
  assign fall_tick = wrap && mdc;

  always_ff @(posedge clk) begin
    if (srst || start || !run) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause 22 / Clause 45 MDIO master: accepts one command at a time over
// valid/ready, serialises the frame on MDC and returns a one-cycle response.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV      = 25,
  parameter int PREAMBLE_LEN = 32,
  parameter bit C45_EN       = 1'b1
) (
  input  logic        clk_125m_i,
  input  logic        srst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_c45_i,
  input  logic [1:0]  cmd_op_i,
  input  logic [4:0]  cmd_phy_addr_i,
  input  logic [4:0]  cmd_reg_addr_i,
  input  logic [15:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i
);

  // Handshake: a command transfers on any cycle where cmd_valid_i and
  // cmd_ready_o are both high; ready is high only while the FSM is idle.
  state_t      state, state_nxt;
  logic [5:0]  bit_cnt, bit_cnt_nxt;
  logic [31:0] frame_sr, frame_sr_nxt;
  logic        is_read, is_read_nxt;
  logic        mdio_nxt, oe_nxt;
  logic [15:0] rd_sr;
  logic        ta_err;
  logic        cmd_fire, c45, op_bad, cmd_is_read, frame_done;
  logic        fall_tick, rise_tick;

  assign cmd_ready_o = (state == S_IDLE);
  assign cmd_fire    = cmd_valid_i && (state == S_IDLE);
  assign c45         = C45_EN && cmd_c45_i;
  assign op_bad      = !c45 && (cmd_op_i != OP_C22_WRITE) && (cmd_op_i != OP_C22_READ);
  assign cmd_is_read = c45 ? cmd_op_i[1] : (cmd_op_i == OP_C22_READ);
  assign frame_done  = (state == S_END) && fall_tick;

  mdc_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk_125m_i),
    .srst      (srst_i),
    .start     (cmd_fire),
    .run       (state != S_IDLE),
    .mdc       (mdc_o),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  always_ff @(posedge clk_125m_i) begin
    if (srst_i) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      frame_sr <= '0;
      is_read  <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      frame_sr <= frame_sr_nxt;
      is_read  <= is_read_nxt;
    end
  end

  // frame_sr[31] is always the bit on the wire once past the preamble.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    frame_sr_nxt = frame_sr;
    is_read_nxt  = is_read;
    unique case (state)
      S_IDLE: begin
        if (cmd_fire && !op_bad) begin
          is_read_nxt  = cmd_is_read;
          frame_sr_nxt = {(c45 ? ST_C45 : ST_C22), cmd_op_i, cmd_phy_addr_i,
                          cmd_reg_addr_i, TA_WRITE, cmd_wdata_i};
          if (PREAMBLE_LEN > 0) begin
            state_nxt   = S_PRE;
            bit_cnt_nxt = 6'(PREAMBLE_LEN - 1);
          end else begin
            state_nxt   = S_HDR;
            bit_cnt_nxt = 6'(HDR_BITS - 1);
          end
        end
      end
      S_PRE: begin
        if (fall_tick) begin
          if (bit_cnt == 6'd0) begin
            state_nxt   = S_HDR;
            bit_cnt_nxt = 6'(HDR_BITS - 1);
          end else begin
            bit_cnt_nxt = bit_cnt - 6'd1;
          end
        end
      end
      S_HDR, S_TA, S_DATA: begin
        if (fall_tick) begin
          frame_sr_nxt = {frame_sr[30:0], 1'b0};
          if (bit_cnt == 6'd0) begin
            if (state == S_HDR) begin
              state_nxt   = S_TA;
              bit_cnt_nxt = 6'(TA_BITS - 1);
            end else if (state == S_TA) begin
              state_nxt   = S_DATA;
              bit_cnt_nxt = 6'(DATA_BITS - 1);
            end else begin
              state_nxt   = S_END;
              bit_cnt_nxt = 6'd0;
            end
          end else begin
            bit_cnt_nxt = bit_cnt - 6'd1;
          end
        end
      end
      S_END: begin
        if (fall_tick) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pad drive for the bit that starts on the coming edge.
  always_comb begin
    oe_nxt   = 1'b0;
    mdio_nxt = 1'b1;
    unique case (state_nxt)
      S_PRE: oe_nxt = 1'b1;
      S_HDR: begin
        oe_nxt   = 1'b1;
        mdio_nxt = frame_sr_nxt[31];
      end
      S_TA, S_DATA: begin
        if (!is_read_nxt) begin
          oe_nxt   = 1'b1;
          mdio_nxt = frame_sr_nxt[31];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_125m_i) begin
    if (srst_i) begin
      mdio_o      <= 1'b1;
      mdio_oe_o   <= 1'b0;
      rd_sr       <= '0;
      ta_err      <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      mdio_o      <= mdio_nxt;
      mdio_oe_o   <= oe_nxt;
      rsp_valid_o <= 1'b0;
      if (cmd_fire) begin
        rd_sr  <= '0;
        ta_err <= 1'b0;
      end
      if (rise_tick && (state == S_TA) && (bit_cnt == 6'd0)) ta_err <= mdio_i;
      if (rise_tick && (state == S_DATA)) rd_sr <= {rd_sr[14:0], mdio_i};
      if (cmd_fire && op_bad) begin
        rsp_valid_o <= 1'b1;
        rsp_err_o   <= 1'b1;
        rsp_rdata_o <= '0;
      end else if (frame_done) begin
        rsp_valid_o <= 1'b1;
        rsp_err_o   <= is_read && ta_err;
        rsp_rdata_o <= is_read ? rd_sr : 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: a default-parameter instance and a fast
// (CLK_DIV=2, no preamble) instance, checked against a frame-level model.
module tb_mdio_master;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic        srst;
  logic        cmd_valid, cmd_c45;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_phy, cmd_reg;
  logic [15:0] cmd_wdata;
  logic        mdio_i;
  logic        sel;

  logic        a_ready, a_rsp_valid, a_err, a_mdc, a_mdio, a_oe;
  logic [15:0] a_rdata;
  logic        b_ready, b_rsp_valid, b_err, b_mdc, b_mdio, b_oe;
  logic [15:0] b_rdata;

  logic        d_ready, d_rsp_valid, d_err, d_mdc, d_mdio, d_oe;
  logic [15:0] d_rdata;

  int total = 0;
  int bad   = 0;
  int cur_pl, cur_div;
  logic [15:0] exp_q[$];

  mdio_master #(.CLK_DIV(25), .PREAMBLE_LEN(32), .C45_EN(1'b1)) u_a (
    .clk_125m_i     (clk),
    .srst_i         (srst),
    .cmd_valid_i    (cmd_valid & ~sel),
    .cmd_ready_o    (a_ready),
    .cmd_c45_i      (cmd_c45),
    .cmd_op_i       (cmd_op),
    .cmd_phy_addr_i (cmd_phy),
    .cmd_reg_addr_i (cmd_reg),
    .cmd_wdata_i    (cmd_wdata),
    .rsp_valid_o    (a_rsp_valid),
    .rsp_rdata_o    (a_rdata),
    .rsp_err_o      (a_err),
    .mdc_o          (a_mdc),
    .mdio_o         (a_mdio),
    .mdio_oe_o      (a_oe),
    .mdio_i         (mdio_i)
  );

  mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(0), .C45_EN(1'b1)) u_b (
    .clk_125m_i     (clk),
    .srst_i         (srst),
    .cmd_valid_i    (cmd_valid & sel),
    .cmd_ready_o    (b_ready),
    .cmd_c45_i      (cmd_c45),
    .cmd_op_i       (cmd_op),
    .cmd_phy_addr_i (cmd_phy),
    .cmd_reg_addr_i (cmd_reg),
    .cmd_wdata_i    (cmd_wdata),
    .rsp_valid_o    (b_rsp_valid),
    .rsp_rdata_o    (b_rdata),
    .rsp_err_o      (b_err),
    .mdc_o          (b_mdc),
    .mdio_o         (b_mdio),
    .mdio_oe_o      (b_oe),
    .mdio_i         (mdio_i)
  );

  always_comb begin
    d_ready     = sel ? b_ready     : a_ready;
    d_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    d_err       = sel ? b_err       : a_err;
    d_mdc       = sel ? b_mdc       : a_mdc;
    d_mdio      = sel ? b_mdio      : a_mdio;
    d_oe        = sel ? b_oe        : a_oe;
    d_rdata     = sel ? b_rdata     : a_rdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic use_inst(input logic s);
    sel     = s;
    cur_pl  = s ? 0 : 32;
    cur_div = s ? 2 : 25;
  endtask

  // Behavioural PHY: answers read frames with TA bit 2 and the data word.
  function automatic logic phy_bit(int k, logic is_rd, logic present, logic ta2, logic [15:0] d);
    if (!is_rd || !present) return 1'b1;
    if (k == cur_pl + 15) return ta2;
    if (k >= cur_pl + 16 && k <= cur_pl + 31) return d[15 - (k - cur_pl - 16)];
    return 1'b1;
  endfunction

  task automatic run_frame(input logic c45, input logic [1:0] op, input logic [4:0] phy,
                           input logic [4:0] rg, input logic [15:0] wd, input logic present,
                           input logic [15:0] pdata, input logic ta2);
    int n, lat, got_c, mdc_bad, rdy_bad, nbits, k;
    logic is_rd, b, o, prev_mdc, exp_mdc, ee;
    logic [31:0] fw;
    logic [127:0] eb, eo, cb, co;
    logic [15:0] er;
    is_rd = c45 ? op[1] : (op == 2'b10);
    n     = cur_pl + 33;
    lat   = 1 + n * 2 * cur_div;
    fw    = {(c45 ? 2'b00 : 2'b01), op, phy, rg, 2'b10, wd};
    eb = '0; eo = '0; cb = '0; co = '0;
    for (int i = 0; i < n; i++) begin
      if (i < cur_pl) b = 1'b1;
      else if (i < cur_pl + 32) b = fw[31 - (i - cur_pl)];
      else b = 1'b1;
      o  = (i < cur_pl + 14) || (!is_rd && (i < cur_pl + 32));
      eb = {eb[126:0], b & o};
      eo = {eo[126:0], o};
    end
    er = !is_rd ? 16'h0000 : (present ? pdata : 16'hFFFF);
    ee = is_rd && (!present || ta2);
    exp_q.push_back(er);

    check("ready_before_accept", d_ready, 1);
    cmd_c45 = c45; cmd_op = op; cmd_phy = phy; cmd_reg = rg; cmd_wdata = wd;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_c45 = 1'($urandom); cmd_op = 2'($urandom); cmd_phy = 5'($urandom);
    cmd_reg = 5'($urandom); cmd_wdata = 16'($urandom);

    got_c = -1; mdc_bad = 0; rdy_bad = 0; nbits = 0; prev_mdc = 1'b0;
    for (int c = 1; c <= lat + 20; c++) begin
      if (d_rsp_valid) begin
        got_c = c;
        break;
      end
      if (d_ready !== 1'b0) rdy_bad++;
      exp_mdc = ((c - 1) % (2 * cur_div)) >= cur_div;
      if (d_mdc !== exp_mdc) mdc_bad++;
      if (d_mdc && !prev_mdc) begin
        cb = {cb[126:0], d_mdio & d_oe};
        co = {co[126:0], d_oe};
        nbits++;
      end
      prev_mdc = d_mdc;
      k = (c - 1) / (2 * cur_div);
      mdio_i = phy_bit(k, is_rd, present, ta2, pdata);
      tick();
    end
    mdio_i = 1'b1;

    check("rsp_latency", got_c, lat);
    check("bit_count", nbits, n);
    check("serial_bits", cb, eb);
    check("oe_per_bit", co, eo);
    check("mdc_waveform", mdc_bad, 0);
    check("ready_low_in_frame", rdy_bad, 0);
    check("ready_in_rsp_cycle", d_ready, 1);
    check("rsp_err", d_err, ee);
    er = exp_q.pop_front();
    check("rsp_rdata", d_rdata, er);
  endtask

  task automatic run_invalid(input logic [1:0] op);
    int act;
    check("inv_ready", d_ready, 1);
    cmd_c45 = 1'b0; cmd_op = op; cmd_phy = 5'($urandom); cmd_reg = 5'($urandom);
    cmd_wdata = 16'($urandom);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("inv_rsp_valid", d_rsp_valid, 1);
    check("inv_rsp_err", d_err, 1);
    check("inv_rsp_rdata", d_rdata, 0);
    check("inv_ready_c1", d_ready, 1);
    act = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (d_mdc || d_oe || d_rsp_valid) act++;
    end
    check("inv_no_activity", act, 0);
  endtask

  initial begin
    int quiet;
    logic c45r;
    logic [1:0] opr;
    srst = 1'b1; cmd_valid = 1'b0; cmd_c45 = 1'b0; cmd_op = 2'b00;
    cmd_phy = '0; cmd_reg = '0; cmd_wdata = '0; mdio_i = 1'b1;
    use_inst(1'b0);
    repeat (3) tick();

    for (int s = 0; s < 2; s++) begin
      use_inst(s[0]);
      check("rst_mdc", d_mdc, 0);
      check("rst_mdio", d_mdio, 1);
      check("rst_oe", d_oe, 0);
      check("rst_ready", d_ready, 1);
      check("rst_rsp_valid", d_rsp_valid, 0);
      check("rst_rdata", d_rdata, 0);
      check("rst_err", d_err, 0);
    end
    srst = 1'b0;
    tick();

    use_inst(1'b0);
    run_frame(1'b0, 2'b01, 5'h01, 5'h00, 16'h1140, 1'b1, 16'h0000, 1'b0);
    tick();
    run_frame(1'b0, 2'b10, 5'h01, 5'h02, 16'($urandom), 1'b1, 16'h0141, 1'b0);
    run_frame(1'b0, 2'b10, 5'h03, 5'h01, 16'($urandom), 1'b0, 16'h0000, 1'b0);
    run_invalid(2'b11);
    run_invalid(2'b00);
    run_frame(1'b1, 2'b11, 5'($urandom), 5'($urandom), 16'($urandom), 1'b1,
              16'($urandom), 1'b0);

    cmd_c45 = 1'b0; cmd_op = 2'b01; cmd_phy = 5'h07; cmd_reg = 5'h04; cmd_wdata = 16'hA5A5;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c < 500; c++) tick();
    check("pre_rst_oe", d_oe, 1);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check("midrst_mdc", d_mdc, 0);
    check("midrst_oe", d_oe, 0);
    check("midrst_ready", d_ready, 1);
    check("midrst_rsp_valid", d_rsp_valid, 0);
    check("midrst_mdio", d_mdio, 1);
    quiet = 0;
    for (int i = 0; i < 3400; i++) begin
      if (d_rsp_valid || d_mdc || d_oe) quiet++;
      tick();
    end
    check("midrst_quiet", quiet, 0);

    use_inst(1'b1);
    run_frame(1'b1, 2'b00, 5'h02, 5'h01, 16'h1234, 1'b1, 16'h0000, 1'b0);
    run_frame(1'b1, 2'b11, 5'h02, 5'h01, 16'($urandom), 1'b1, 16'hBEEF, 1'b0);
    for (int i = 0; i < 16; i++) begin
      c45r = 1'($urandom);
      opr  = c45r ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 2));
      run_frame(c45r, opr, 5'($urandom), 5'($urandom), 16'($urandom),
                ($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
# mdio_master

Parametrised Clause 22 / Clause 45 MDIO management master that generates MDC and serialises PHY register frames from a valid/ready command interface, replacing the raw MAC-MDIO tristate passthrough with a standalone controller. It sits in the system clock domain next to the MAC. It drives `phy_mdio_mdc` directly. The top-level tristate is built from `mdio_o`/`mdio_oe_o`/`mdio_i`.

## Interface
- `CLK_DIV`, 25: MDC half-period in clock cycles (≥2); default gives 2.5 MHz MDC at 125 MHz.
- `PREAMBLE_LEN`, 32: preamble ones per frame, 0..32; 0 = preamble suppression.
- `C45_EN`, 1: 1 enables Clause 45 frames; 0 forces Clause 22 (`cmd_c45_i` ignored).
- `clk_125m_i` in 1: system clock.
- `srst_i` in 1: synchronous, active-high reset.
- `cmd_valid_i` in 1: command offered.
- `cmd_ready_o` out 1: block idle, accepts command.
- `cmd_c45_i` in 1: 1 = Clause 45 frame.
- `cmd_op_i` in 2: OP field (C22: 01 write, 10 read; C45: 00 addr, 01 write, 11 read, 10 post-read-inc).
- `cmd_phy_addr_i` in 5: PHYAD / PRTAD.
- `cmd_reg_addr_i` in 5: REGAD / DEVAD.
- `cmd_wdata_i` in 16: write data / C45 address.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_rdata_o` out 16: read data (0 for non-read frames).
- `rsp_err_o` out 1: error flag qualified by `rsp_valid_o`.
- `mdc_o` out 1: management clock.
- `mdio_o` out 1: serial data out.
- `mdio_oe_o` out 1: 1 = drive `mdio_o` onto the pad.
- `mdio_i` in 1: pad input.

## Operation
- Command captured on the cycle `cmd_valid_i & cmd_ready_o` is high (cycle 0). Fields are registered, and inputs are don't-care afterwards.
- Frame, MSB first: PREAMBLE_LEN × 1, ST (01 C22 / 00 C45), OP[1:0], PHYAD[4:0], REGAD[4:0], TA[1:0], DATA[15:0], then one END bit.
- Read frame: C22 op 10, or C45 op[1]=1. All other valid ops are write-type.
- Write-type frames drive TA=10 and DATA=wdata for the whole frame (`mdio_oe_o`=1).
- Read frames release the bus (`mdio_oe_o`=0) from the first TA bit through END.
- Second TA bit sampled. If `mdio_i`=1 (no PHY answered), `rsp_err_o`=1. The frame still completes, and `rsp_rdata_o` holds the sampled bits.
- Invalid op (C22 with op 00 or 11; `cmd_c45_i`=1 treated as C22 when `C45_EN`=0): no bus activity. `rsp_valid_o`=1, `rsp_err_o`=1, `rsp_rdata_o`=0 on cycle 1.
- FSM: IDLE → PRE (skipped if PREAMBLE_LEN=0) → HDR (14 bits ST..REGAD) → TA (2) → DATA (16) → END (1) → IDLE.
- END bit: `mdio_oe_o`=0, MDC still toggles.
- `cmd_ready_o`=1 only in IDLE.

## Timing
- Reset (sync): state IDLE. Registered outputs take these values after the reset edge and hold them during reset:
  - `mdc_o`=0, `mdio_o`=1, `mdio_oe_o`=0
  - `cmd_ready_o`=1, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0
- Reset mid-frame aborts immediately, with no response pulse.
- Each bit lasts 2×CLK_DIV cycles. The bit starts with `mdc_o`→0 and the new `mdio_o`/`mdio_oe_o` on the same edge. After CLK_DIV cycles `mdc_o`→1.
- `mdio_i` is registered on the clock edge that sets `mdc_o` 0→1. This applies to the TA bit 2 and DATA bits.
- Bit 0 starts at cycle 1. `cmd_ready_o` is low from cycle 1.
- `rsp_valid_o` is high exactly at cycle 1 + (PREAMBLE_LEN+33)×2×CLK_DIV, with `cmd_ready_o`=1 on the same cycle. Defaults give cycle 3251.
- A new command offered in the response cycle is accepted in that cycle (back-to-back).
- Divider counter width: $clog2(CLK_DIV). Bit counter: 6 bits. It counts down per field and wraps only via state change.

## Structure
- `mdio_pkg`: state enum, ST constants (ST_C22=2'b01, ST_C45=2'b00), op localparams, and the HDR/TA/DATA bit counts.
- Sub-module `mdc_clk_div`: free-running only while not IDLE. It emits `fall_tick`/`rise_tick` strobes and `mdc`. It is reset to the phase with `mdc`=0 and count 0 on start and on `srst_i`.

## Test plan
- C22 write, PHY 5'h01, reg 5'h00, data 16'h1140, defaults:
  - Serial capture on MDC rising = 32×1, 01 01 00001 00000 10 0001000101000000.
  - `rsp_valid_o` at cycle 3251, `rsp_err_o`=0.
- C22 read, PHY model returns 16'h0141 with TA bit 2 = 0:
  - `rsp_rdata_o`=16'h0141, `rsp_err_o`=0.
  - `mdio_oe_o`=0 from the TA start through END.
- C22 read with no PHY (pull-up, `mdio_i`=1) → `rsp_err_o`=1, `rsp_rdata_o`=16'hFFFF.
- C45 address then read (op 00, then 11), DEVAD 5'h01, with `PREAMBLE_LEN`=0 and `CLK_DIV`=2:
  - Frames start with ST=00 and have no preamble.
  - Each response arrives at cycle 1+33×4=133 after its accept.
- C22 op 11:
  - `rsp_valid_o`/`rsp_err_o`=1 on cycle 1, with `mdc_o` and `mdio_oe_o` never toggling.
  - `srst_i` pulsed at cycle 500 of a write → next cycle `mdc_o`=0, `mdio_oe_o`=0, `cmd_ready_o`=1, and no `rsp_valid_o`.
